// File: rtl/lsu_ctrl.sv
// Memory-stage load/store controller: one byte/half/word access per Start against a req/ready + rvalid word memory.
// Optional define MISALIGN_TRAP_EN faults misaligned H/W accesses instead of silently aligning them down.
module lsu_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_Start,
    input  logic        i_MemWrite,
    input  logic [2:0]  i_Funct3,
    input  logic [31:0] i_ALUResult,
    input  logic [31:0] i_WriteData,
    output logic [31:0] o_ReadData,
    output logic        o_Done,
    output logic        o_AccessFault,
    output logic        o_Stall,
    output logic        o_MemReq,
    output logic        o_MemWe,
    output logic [31:0] o_MemAddr,
    output logic [3:0]  o_MemWStrb,
    output logic [31:0] o_MemWData,
    input  logic        i_MemReady,
    input  logic        i_MemRValid,
    input  logic [31:0] i_MemRData
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RD,
        ST_DONE
    } state_t;

    state_t          r_state;
    logic [2:0]      r_funct3;
    logic [1:0]      r_lane;
    logic [TW-1:0]   r_cnt;

    logic [1:0]      w_a;
    logic            w_unsupported;
    logic            w_storeUnsigned;
    logic            w_misalign;
    logic            w_fault;
    logic [3:0]      w_strbRaw;
    logic [3:0]      w_strb;
    logic [31:0]     w_wdata;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_loadExt;
    logic            w_expire;

    assign w_a             = i_ALUResult[1:0];
    assign w_unsupported   = (i_Funct3 == 3'b011) || (i_Funct3 == 3'b110) || (i_Funct3 == 3'b111);
    assign w_storeUnsigned = i_MemWrite && i_Funct3[2];

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((i_Funct3[1:0] == 2'b01) && w_a[0]) ||
                        ((i_Funct3[1:0] == 2'b10) && (w_a != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault  = w_unsupported || w_storeUnsigned || w_misalign;
    assign w_expire = (r_cnt == TW'(TIMEOUT - 1));

    // Store lanes: narrow data is replicated so any strobe picks the right byte.
    always_comb begin
        w_strbRaw = 4'b0000;
        w_wdata   = i_WriteData;
        case (i_Funct3[1:0])
            2'b00: begin
                w_strbRaw = 4'b0001 << w_a;
                w_wdata   = {4{i_WriteData[7:0]}};
            end
            2'b01: begin
                w_strbRaw = w_a[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{i_WriteData[15:0]}};
            end
            2'b10:   w_strbRaw = 4'b1111;
            default: w_strbRaw = 4'b0000;
        endcase
    end

    assign w_strb = i_MemWrite ? w_strbRaw : 4'b0000;

    always_comb begin
        w_byte = i_MemRData[7:0];
        case (r_lane)
            2'b00: w_byte = i_MemRData[7:0];
            2'b01: w_byte = i_MemRData[15:8];
            2'b10: w_byte = i_MemRData[23:16];
            2'b11: w_byte = i_MemRData[31:24];
            default: w_byte = i_MemRData[7:0];
        endcase
        w_half = r_lane[1] ? i_MemRData[31:16] : i_MemRData[15:0];
        case (r_funct3)
            3'b000:  w_loadExt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_loadExt = {{16{w_half[15]}}, w_half};
            3'b100:  w_loadExt = {24'h0, w_byte};
            3'b101:  w_loadExt = {16'h0, w_half};
            default: w_loadExt = i_MemRData;
        endcase
    end

    assign o_Stall = rst_n && (((r_state == ST_IDLE) && i_Start) ||
                               (r_state == ST_REQ) || (r_state == ST_WAIT_RD));

    // Control FSM; every memory-side output is registered and held through REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_funct3      <= 3'b000;
            r_lane        <= 2'b00;
            r_cnt         <= '0;
            o_ReadData    <= 32'h0;
            o_Done        <= 1'b0;
            o_AccessFault <= 1'b0;
            o_MemReq      <= 1'b0;
            o_MemWe       <= 1'b0;
            o_MemAddr     <= 32'h0;
            o_MemWStrb    <= 4'b0000;
            o_MemWData    <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_Start) begin
                        r_funct3 <= i_Funct3;
                        r_lane   <= w_a;
                        if (w_fault) begin
                            r_state       <= ST_DONE;
                            o_Done        <= 1'b1;
                            o_AccessFault <= 1'b1;
                        end else begin
                            r_state    <= ST_REQ;
                            r_cnt      <= '0;
                            o_MemReq   <= 1'b1;
                            o_MemWe    <= i_MemWrite;
                            o_MemAddr  <= {i_ALUResult[31:2], 2'b00};
                            o_MemWStrb <= w_strb;
                            o_MemWData <= w_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (i_MemReady) begin
                        o_MemReq   <= 1'b0;
                        o_MemWe    <= 1'b0;
                        o_MemWStrb <= 4'b0000;
                        r_cnt      <= r_cnt + TW'(1);
                        if (o_MemWe) begin
                            r_state <= ST_DONE;
                            o_Done  <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT_RD;
                        end
                    end else if (w_expire) begin
                        r_state       <= ST_DONE;
                        o_Done        <= 1'b1;
                        o_AccessFault <= 1'b1;
                        o_ReadData    <= 32'h0;
                        o_MemReq      <= 1'b0;
                        o_MemWe       <= 1'b0;
                        o_MemWStrb    <= 4'b0000;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                ST_WAIT_RD: begin
                    if (i_MemRValid) begin
                        r_state    <= ST_DONE;
                        o_Done     <= 1'b1;
                        o_ReadData <= w_loadExt;
                    end else if (w_expire) begin
                        r_state       <= ST_DONE;
                        o_Done        <= 1'b1;
                        o_AccessFault <= 1'b1;
                        o_ReadData    <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                ST_DONE: begin
                    r_state       <= ST_IDLE;
                    o_Done        <= 1'b0;
                    o_AccessFault <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
